// File: rtl/ibex_fetch_req_ctrl.sv
// ibex_fetch_req_ctrl: instruction-bus fetch request controller feeding the fetch FIFO
module ibex_fetch_req_ctrl #(
  parameter int          NUM_REQS = 2,
  parameter logic [31:0] BootAddr = 32'h0000_0080
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_i,
  input  logic                branch_i,
  input  logic [31:0]         addr_i,
  output logic                busy_o,
  input  logic [NUM_REQS-1:0] fifo_busy_i,
  output logic                fifo_clear_o,
  output logic                fifo_valid_o,
  output logic [31:0]         fifo_addr_o,
  output logic [31:0]         fifo_rdata_o,
  output logic                fifo_err_o,
  output logic                instr_req_o,
  input  logic                instr_gnt_i,
  output logic [31:0]         instr_addr_o,
  input  logic                instr_rvalid_i,
  input  logic [31:0]         instr_rdata_i,
  input  logic                instr_err_i
);
  localparam int CW = $clog2(NUM_REQS + 1);
  typedef enum logic {IDLE, REQ} state_e;
  state_e              state;
  logic [CW-1:0]       cnt, cnt_p, cnt_n;
  logic [NUM_REQS-1:0] disc, disc_b, disc_n;
  logic [31:0]         fetch_addr, redir_addr, target;
  logic                pend_disc, grant, room, room_n;
  int                  fifo_occ;
  assign grant        = instr_req_o & instr_gnt_i;
  assign target       = {addr_i[31:2], 2'b00};
  assign cnt_p        = cnt - CW'(instr_rvalid_i);
  assign cnt_n        = cnt_p + CW'(grant);
  assign instr_req_o  = state == REQ;
  assign instr_addr_o = fetch_addr;
  assign busy_o       = instr_req_o | (cnt != '0);
  assign fifo_clear_o = branch_i;
  assign fifo_addr_o  = addr_i;
  assign fifo_rdata_o = instr_rdata_i;
  assign fifo_err_o   = instr_err_i;
  assign fifo_valid_o = instr_rvalid_i & ~disc[0] & ~branch_i;
  // Slots above the count hold stale bits; a push always rewrites its own slot.
  always_comb begin
    fifo_occ = 0;
    for (int i = 0; i < NUM_REQS; i++) fifo_occ += int'(fifo_busy_i[i]);
    room   = int'(cnt) + fifo_occ < NUM_REQS;
    room_n = int'(cnt_n) + fifo_occ < NUM_REQS;
    disc_b = branch_i ? '1 : disc;
    disc_n = instr_rvalid_i ? disc_b >> 1 : disc_b;
    for (int i = 0; i < NUM_REQS; i++)
      disc_n[i] = (grant && cnt_p == CW'(i)) ? (branch_i | pend_disc) : disc_n[i];
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      cnt        <= '0;
      disc       <= '0;
      fetch_addr <= BootAddr;
      redir_addr <= '0;
      pend_disc  <= 1'b0;
    end else begin
      cnt   <= cnt_n;
      disc  <= disc_n;
      state <= (state == IDLE) ? ((req_i && room) ? REQ : IDLE)
                               : ((instr_gnt_i && !(req_i && room_n)) ? IDLE : REQ);
      // An ungranted request keeps its address; the redirect is applied once it is granted.
      if (branch_i && instr_req_o && !instr_gnt_i) begin
        pend_disc  <= 1'b1;
        redir_addr <= target;
      end else if (branch_i) begin
        fetch_addr <= target;
        pend_disc  <= 1'b0;
      end else if (grant) begin
        fetch_addr <= pend_disc ? redir_addr : fetch_addr + 32'd4;
        pend_disc  <= 1'b0;
      end
    end
  end
  assert property (@(posedge clk_i) disable iff (rst_i) !(instr_rvalid_i && cnt == '0));
  assert property (@(posedge clk_i) disable iff (rst_i) !(fifo_valid_o && fifo_busy_i[NUM_REQS-1]));
endmodule

// File: tb/tb_ibex_fetch_req_ctrl.sv
// tb_ibex_fetch_req_ctrl: directed scoreboard bench for the fetch request controller
module tb_ibex_fetch_req_ctrl;
  logic        clk_i, rst_i, req_i, branch_i, busy_o, fifo_clear_o, fifo_valid_o, fifo_err_o;
  logic        instr_req_o, instr_gnt_i, instr_rvalid_i, instr_err_i, rsp_en;
  logic [1:0]  fifo_busy_i;
  logic [31:0] addr_i, fifo_addr_o, fifo_rdata_o, instr_addr_o, instr_rdata_i;
  logic [31:0] exp_a[$], pend[$];
  logic [32:0] exp_d[$];
  int          checks = 0, errors = 0;

  ibex_fetch_req_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .branch_i(branch_i), .addr_i(addr_i),
    .busy_o(busy_o), .fifo_busy_i(fifo_busy_i), .fifo_clear_o(fifo_clear_o),
    .fifo_valid_o(fifo_valid_o), .fifo_addr_o(fifo_addr_o), .fifo_rdata_o(fifo_rdata_o),
    .fifo_err_o(fifo_err_o), .instr_req_o(instr_req_o), .instr_gnt_i(instr_gnt_i),
    .instr_addr_o(instr_addr_o), .instr_rvalid_i(instr_rvalid_i),
    .instr_rdata_i(instr_rdata_i), .instr_err_i(instr_err_i)
  );

  initial begin
    clk_i = 0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #100000;
    $display("FAIL timeout reached");
    $fatal(1);
  end

  function automatic logic [32:0] mem(input logic [31:0] a);
    return {a[3], a ^ 32'h5a5a_0000};
  endfunction

  task automatic chk(input string n, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", n, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic expect_fetch(input logic [31:0] a, input bit kept);
    exp_a.push_back(a);
    if (kept) exp_d.push_back(mem(a));
  endtask

  task automatic do_reset();
    chk("drain_addr_q", 33'(exp_a.size()), 0);
    chk("drain_data_q", 33'(exp_d.size()), 0);
    exp_a.delete();
    exp_d.delete();
    rst_i = 1; req_i = 0; branch_i = 0; addr_i = 0; fifo_busy_i = 0; instr_gnt_i = 0; rsp_en = 0;
    @(negedge clk_i);
    chk("rst_req", 33'(instr_req_o), 0);
    chk("rst_busy", 33'(busy_o), 0);
    chk("rst_addr", 33'(instr_addr_o), 33'h80);
    step(1);
    rst_i = 0;
  endtask

  // Bus slave: returns each granted word in order, one cycle after its grant at the earliest.
  initial begin
    instr_rvalid_i = 0; instr_rdata_i = 0; instr_err_i = 0;
    forever begin
      @(negedge clk_i);
      if (rst_i) pend.delete();
      else begin
        if (instr_rvalid_i && pend.size() > 0) void'(pend.pop_front());
        if (instr_req_o && instr_gnt_i) pend.push_back(instr_addr_o);
      end
      @(posedge clk_i);
      #2;
      instr_rvalid_i = rsp_en && !rst_i && pend.size() > 0;
      {instr_err_i, instr_rdata_i} = pend.size() > 0 ? mem(pend[0]) : '0;
    end
  end

  // Scoreboard monitor: grants against expected addresses, FIFO pushes against expected data.
  always @(negedge clk_i) begin
    if (!rst_i && instr_req_o && instr_gnt_i) begin
      if (exp_a.size() == 0) begin
        checks++; errors++;
        $display("FAIL grant_addr unexpected grant addr %h", instr_addr_o);
      end else chk("grant_addr", 33'(instr_addr_o), 33'(exp_a.pop_front()));
    end
    if (!rst_i && fifo_valid_o) begin
      if (exp_d.size() == 0) begin
        checks++; errors++;
        $display("FAIL fifo_push unexpected push data %h", fifo_rdata_o);
      end else chk("fifo_push", {fifo_err_o, fifo_rdata_o}, exp_d.pop_front());
    end
  end

  initial begin
    rst_i = 1;
    // 1: streaming fetch, one grant per cycle, responses one cycle later
    do_reset();
    for (int i = 0; i < 5; i++) expect_fetch(32'h80 + 32'(4 * i), 1);
    req_i = 1; instr_gnt_i = 1; rsp_en = 1;
    step(5);
    req_i = 0;
    step(1);
    instr_gnt_i = 0;
    step(3);
    @(negedge clk_i);
    chk("t1_busy_idle", 33'(busy_o), 0);
    chk("t1_next_addr", 33'(instr_addr_o), 33'h94);
    // 2: full FIFO blocks requests until released
    do_reset();
    fifo_busy_i = 2'b11; req_i = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("t2_blocked", 33'(instr_req_o), 0);
      step(1);
    end
    fifo_busy_i = 2'b00;
    @(negedge clk_i);
    chk("t2_release_lag", 33'(instr_req_o), 0);
    step(1);
    @(negedge clk_i);
    chk("t2_req", 33'(instr_req_o), 1);
    chk("t2_addr", 33'(instr_addr_o), 33'h80);
    // 3: two outstanding, responses withheld
    do_reset();
    expect_fetch(32'h80, 1); expect_fetch(32'h84, 1);
    req_i = 1; instr_gnt_i = 1;
    step(3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("t3_no_third", 33'(instr_req_o), 0);
      chk("t3_busy", 33'(busy_o), 1);
      step(1);
    end
    rsp_en = 1; req_i = 0;
    step(4);
    @(negedge clk_i);
    chk("t3_drained", 33'(busy_o), 0);
    // 4: branch with two outstanding drops both responses
    do_reset();
    expect_fetch(32'h80, 0); expect_fetch(32'h84, 0);
    req_i = 1; instr_gnt_i = 1;
    step(3);
    branch_i = 1; addr_i = 32'h1002; instr_gnt_i = 0;
    @(negedge clk_i);
    chk("t4_clear", 33'(fifo_clear_o), 1);
    chk("t4_fifo_addr", 33'(fifo_addr_o), 33'h1002);
    chk("t4_busy", 33'(busy_o), 1);
    step(1);
    branch_i = 0; rsp_en = 1;
    step(2);
    expect_fetch(32'h1000, 1);
    instr_gnt_i = 1; req_i = 0;
    @(negedge clk_i);
    chk("t4_req", 33'(instr_req_o), 1);
    chk("t4_target", 33'(instr_addr_o), 33'h1000);
    step(1);
    instr_gnt_i = 0;
    step(3);
    @(negedge clk_i);
    chk("t4_drained", 33'(busy_o), 0);
    // 5: branch during an ungranted request at 0x90
    do_reset();
    for (int i = 0; i < 3; i++) expect_fetch(32'h80 + 32'(4 * i), 1);
    expect_fetch(32'h8c, 0); expect_fetch(32'h90, 0); expect_fetch(32'h1000, 1);
    req_i = 1; instr_gnt_i = 1; rsp_en = 1;
    step(5);
    instr_gnt_i = 0; branch_i = 1; addr_i = 32'h1002;
    @(negedge clk_i);
    chk("t5_clear", 33'(fifo_clear_o), 1);
    chk("t5_held", 33'(instr_addr_o), 33'h90);
    step(1);
    branch_i = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      chk("t5_req_held", 33'(instr_req_o), 1);
      chk("t5_addr_held", 33'(instr_addr_o), 33'h90);
      step(1);
    end
    instr_gnt_i = 1;
    step(1);
    req_i = 0;
    @(negedge clk_i);
    chk("t5_target", 33'(instr_addr_o), 33'h1000);
    step(1);
    instr_gnt_i = 0;
    step(3);
    @(negedge clk_i);
    chk("t5_drained", 33'(busy_o), 0);
    // 6: rvalid, grant and branch in the same cycle
    do_reset();
    expect_fetch(32'h80, 1); expect_fetch(32'h84, 0); expect_fetch(32'h88, 0);
    expect_fetch(32'h2000, 1);
    req_i = 1; instr_gnt_i = 1; rsp_en = 1;
    step(3);
    branch_i = 1; addr_i = 32'h2000;
    @(negedge clk_i);
    chk("t6_rvalid", 33'(instr_rvalid_i), 1);
    chk("t6_no_push", 33'(fifo_valid_o), 0);
    chk("t6_clear", 33'(fifo_clear_o), 1);
    step(1);
    branch_i = 0; req_i = 0;
    @(negedge clk_i);
    chk("t6_target", 33'(instr_addr_o), 33'h2000);
    chk("t6_count_kept", 33'(busy_o), 1);
    step(1);
    instr_gnt_i = 0;
    step(3);
    @(negedge clk_i);
    chk("t6_drained", 33'(busy_o), 0);
    chk("end_addr_q", 33'(exp_a.size()), 0);
    chk("end_data_q", 33'(exp_d.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
